// File: rtl/cp_pulse_ctrl.sv
// cp_pulse_ctrl -- charge-pump pulse sequencer with lock detection.
//
// Turns synchronized PFD up/down samples into fixed-width charge-pump pulses.
// Each pulse is followed by one dead cycle. A request that arrives while a
// pulse is running is held in a one-deep pending flag and served afterwards.
// Simultaneous up and down requests are "balanced events": no pump fires and
// the lock counter advances instead. locked is raised after lock_thresh
// consecutive balanced events.
//
// Ports:
//   wb_clk_i     system clock, rising edge
//   wb_rst_i     synchronous active-high reset
//   en           block enable; 0 returns to IDLE with the pumps off
//   up_req       PFD up sample (level, per cycle)
//   dn_req       PFD down sample (level, per cycle)
//   pulse_len    pump pulse width minus 1, captured at pump entry
//   lock_thresh  balanced events needed for lock (0 behaves as 1)
//   upbar        up pump drive, active-low
//   down         down pump drive, active-high
//   busy         FSM not in IDLE
//   locked       registered lock indication
//   up_cnt       up-pulse count (saturating, stats build only, else 0)
//   dn_cnt       down-pulse count (saturating, stats build only, else 0)
//
// Macros:
//   CP_CTRL_STATS_EN  enables the up_cnt/dn_cnt pulse counters
//   USE_POWER_PINS    adds the vccd1/vssd1 supply pins
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | pumps off, waiting for an effective request
// PUMP_UP  | upbar low, pulse counter running down
// PUMP_DN  | down high, pulse counter running down
// DEAD     | one cycle with both pumps off before IDLE

module cp_pulse_ctrl (
`ifdef USE_POWER_PINS
    inout  wire         vccd1,
    inout  wire         vssd1,
`endif
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        en,
    input  logic        up_req,
    input  logic        dn_req,
    input  logic [3:0]  pulse_len,
    input  logic [7:0]  lock_thresh,
    output logic        upbar,
    output logic        down,
    output logic        busy,
    output logic        locked,
    output logic [15:0] up_cnt,
    output logic [15:0] dn_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PUMP_UP = 2'd1,
        S_PUMP_DN = 2'd2,
        S_DEAD    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  pulse_cnt;
    logic        pend_up;
    logic        pend_dn;
    logic        pend_bal;
    logic [7:0]  lock_cnt;

    logic        eff_up;
    logic        eff_dn;
    logic        in_idle;
    logic        enter_up;
    logic        enter_dn;
    logic        nxt_pend_up;
    logic        nxt_pend_dn;
    logic        bal_busy;
    logic        bal_event;
    logic [7:0]  thresh_eff;

    assign eff_up      = up_req | pend_up;
    assign eff_dn      = dn_req | pend_dn;
    assign in_idle     = (state == S_IDLE);
    assign enter_up    = en && in_idle && eff_up && !eff_dn;
    assign enter_dn    = en && in_idle && eff_dn && !eff_up;

    // Requests collected while busy; both directions together cancel out.
    assign nxt_pend_up = pend_up | up_req;
    assign nxt_pend_dn = pend_dn | dn_req;
    assign bal_busy    = nxt_pend_up && nxt_pend_dn;

    // A balance seen while busy is credited on the DEAD -> IDLE edge,
    // including one that completes during the DEAD cycle itself.
    assign bal_event   = en && ((in_idle && eff_up && eff_dn) ||
                                ((state == S_DEAD) && (pend_bal || bal_busy)));

    assign thresh_eff  = (lock_thresh == 8'd0) ? 8'd1 : lock_thresh;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (enter_up)      state_nxt = S_PUMP_UP;
                else if (enter_dn) state_nxt = S_PUMP_DN;
            end
            S_PUMP_UP,
            S_PUMP_DN: begin
                if (pulse_cnt == 4'd0) state_nxt = S_DEAD;
            end
            S_DEAD:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (!en) state_nxt = S_IDLE;
    end

    // Outputs decoded from the registered state, so the two pumps can never
    // be on together.
    always_comb begin
        upbar = 1'b1;
        down  = 1'b0;
        busy  = 1'b1;
        case (state)
            S_PUMP_UP: upbar = 1'b0;
            S_PUMP_DN: down  = 1'b1;
            S_IDLE:    busy  = 1'b0;
            default: ;
        endcase
    end

    // Pulse width down-counter, loaded on pump entry.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pulse_cnt <= 4'd0;
        end else if (enter_up || enter_dn) begin
            pulse_cnt <= pulse_len;
        end else if (pulse_cnt != 4'd0) begin
            pulse_cnt <= pulse_cnt - 4'd1;
        end
    end

    // Pending flags. In IDLE every request is consumed at once (pump entry
    // or balanced event), so the flags simply clear there.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !en || in_idle) begin
            pend_up  <= 1'b0;
            pend_dn  <= 1'b0;
            pend_bal <= 1'b0;
        end else if (state == S_DEAD) begin
            pend_up  <= nxt_pend_up && !bal_busy;
            pend_dn  <= nxt_pend_dn && !bal_busy;
            pend_bal <= 1'b0;
        end else if (bal_busy) begin
            pend_up  <= 1'b0;
            pend_dn  <= 1'b0;
            pend_bal <= 1'b1;
        end else begin
            pend_up  <= nxt_pend_up;
            pend_dn  <= nxt_pend_dn;
        end
    end

    // Lock counter and indication; both freeze while disabled.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            lock_cnt <= 8'd0;
            locked   <= 1'b0;
        end else if (en) begin
            locked <= (lock_cnt >= thresh_eff);
            if (enter_up || enter_dn)
                lock_cnt <= 8'd0;
            else if (bal_event && lock_cnt != 8'hFF)
                lock_cnt <= lock_cnt + 8'd1;
        end
    end

`ifdef CP_CTRL_STATS_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            up_cnt <= 16'd0;
            dn_cnt <= 16'd0;
        end else begin
            if (enter_up && up_cnt != 16'hFFFF) up_cnt <= up_cnt + 16'd1;
            if (enter_dn && dn_cnt != 16'hFFFF) dn_cnt <= dn_cnt + 16'd1;
        end
    end
`else
    assign up_cnt = 16'd0;
    assign dn_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cp_pulse_ctrl.sv
// Directed bench for cp_pulse_ctrl. Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
module tb_cp_pulse_ctrl;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        en;
    logic        up_req;
    logic        dn_req;
    logic [3:0]  pulse_len;
    logic [7:0]  lock_thresh;
    logic        upbar;
    logic        down;
    logic        busy;
    logic        locked;
    logic [15:0] up_cnt;
    logic [15:0] dn_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    cp_pulse_ctrl dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .en          (en),
        .up_req      (up_req),
        .dn_req      (dn_req),
        .pulse_len   (pulse_len),
        .lock_thresh (lock_thresh),
        .upbar       (upbar),
        .down        (down),
        .busy        (busy),
        .locked      (locked),
        .up_cnt      (up_cnt),
        .dn_cnt      (dn_cnt)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One isolated pulse: measure its width, then the DEAD and IDLE cycles.
    task automatic do_pulse(input bit is_up, input logic [3:0] len);
        int w;
        w = 0;
        pulse_len = len;
        if (is_up) up_req = 1'b1;
        else       dn_req = 1'b1;
        tick();
        up_req = 1'b0;
        dn_req = 1'b0;
        while ((is_up ? !upbar : down) && w < 40) begin
            w++;
            tick();
        end
        chk(is_up ? "up_width" : "dn_width", w, int'(len) + 1);
        chk("dead_busy", {30'd0, upbar, busy}, 32'd3);
        tick();
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int low;
        int nbusy;
        int w;
        bit overlap;

        wb_rst_i = 1'b1;
        en = 1'b1;
        up_req = 1'b0;
        dn_req = 1'b0;
        pulse_len = 4'd0;
        lock_thresh = 8'd2;
        tick();
        tick();
        chk("rst_upbar", upbar, 1);
        chk("rst_down", down, 0);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_cnts", {up_cnt, dn_cnt}, 0);
        wb_rst_i = 1'b0;
        tick();

        // Single up request, pulse_len=3: 4 low cycles starting one cycle later.
        pulse_len = 4'd3;
        up_req = 1'b1;
        chk("r20_pre_upbar", upbar, 1);
        tick();
        up_req = 1'b0;
        low = 0;
        nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            if (!upbar) low++;
            if (busy) nbusy++;
            if (i < 4) chk("r20_upbar_low", upbar, 0);
            tick();
        end
        chk("r20_low_cycles", low, 4);
        chk("r20_busy_cycles", nbusy, 5);

        // Two balanced events with lock_thresh=2.
        lock_thresh = 8'd2;
        up_req = 1'b1;
        dn_req = 1'b1;
        tick();
        chk("r21_nopump1", {29'd0, upbar, down, busy}, 32'd4);
        chk("r21_locked1", locked, 0);
        tick();
        up_req = 1'b0;
        dn_req = 1'b0;
        chk("r21_nopump2", {29'd0, upbar, down, busy}, 32'd4);
        chk("r21_locked_lag", locked, 0);
        tick();
        chk("r21_locked", locked, 1);

        // dn request during a pulse_len=5 up pulse.
        pulse_len = 4'd5;
        up_req = 1'b1;
        tick();
        up_req = 1'b0;
        dn_req = 1'b1;
        tick();
        dn_req = 1'b0;
        overlap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!upbar && down) overlap = 1'b1;
            tick();
        end
        chk("r22_up_last", upbar, 0);
        tick();
        chk("r22_dead", {29'd0, upbar, down, busy}, 32'd5);
        tick();
        chk("r22_idle_gap", {29'd0, upbar, down, busy}, 32'd4);
        tick();
        chk("r22_down_on", down, 1);
        w = 0;
        while (busy && w < 40) begin
            if (!upbar && down) overlap = 1'b1;
            w++;
            tick();
        end
        chk("r22_dn_len", w, 7);
        chk("r22_no_overlap", overlap, 0);

        // Both requests during a pulse: no follow-on pump, one balanced event.
        lock_thresh = 8'd1;
        pulse_len = 4'd2;
        up_req = 1'b1;
        tick();
        up_req = 1'b1;
        dn_req = 1'b1;
        tick();
        up_req = 1'b0;
        dn_req = 1'b0;
        tick();
        tick();
        chk("r22b_dead", busy, 1);
        tick();
        chk("r22b_idle", busy, 0);
        chk("r22b_locked_lag", locked, 0);
        tick();
        chk("r22b_locked", locked, 1);
        chk("r22b_no_pump", {29'd0, upbar, down, busy}, 32'd4);
        tick();
        chk("r22b_still_idle", busy, 0);

        // Reset in the middle of a down pulse.
        pulse_len = 4'd7;
        dn_req = 1'b1;
        tick();
        dn_req = 1'b0;
        tick();
        tick();
        chk("r23_mid_down", down, 1);
        wb_rst_i = 1'b1;
        en = 1'b0;
        tick();
        chk("r23_down", down, 0);
        chk("r23_busy", busy, 0);
        chk("r23_locked", locked, 0);
        chk("r23_cnts", {up_cnt, dn_cnt}, 0);
        wb_rst_i = 1'b0;
        en = 1'b1;
        tick();

        // Disable in the first cycle of an up pulse while locked.
        lock_thresh = 8'd1;
        up_req = 1'b1;
        dn_req = 1'b1;
        tick();
        up_req = 1'b0;
        dn_req = 1'b0;
        tick();
        chk("r24_locked_pre", locked, 1);
        pulse_len = 4'd5;
        up_req = 1'b1;
        tick();
        up_req = 1'b0;
        chk("r24_upbar_low", upbar, 0);
        en = 1'b0;
        tick();
        chk("r24_upbar_off", upbar, 1);
        chk("r24_busy_off", busy, 0);
        chk("r24_locked_held", locked, 1);
        tick();
        chk("r24_locked_held2", locked, 1);
        en = 1'b1;
        tick();
        up_req = 1'b1;
        dn_req = 1'b1;
        tick();
        up_req = 1'b0;
        dn_req = 1'b0;
        tick();
        chk("r24_relocked", locked, 1);
        pulse_len = 4'd2;
        up_req = 1'b1;
        tick();
        up_req = 1'b0;
        tick();
        chk("r24_entry_unlock", locked, 0);
        w = 0;
        while (busy && w < 40) begin
            w++;
            tick();
        end
        chk("r24_settle", busy, 0);

        // Pulse statistics and width boundaries.
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        tick();
        do_pulse(1'b1, 4'd0);
        do_pulse(1'b0, 4'd15);
        do_pulse(1'b1, 4'd15);
        do_pulse(1'b0, 4'd0);
        do_pulse(1'b1, 4'd1);
`ifdef CP_CTRL_STATS_EN
        chk("r25_up_cnt", up_cnt, 3);
        chk("r25_dn_cnt", dn_cnt, 2);
`else
        chk("r25_up_cnt", up_cnt, 0);
        chk("r25_dn_cnt", dn_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end of test");
        $fatal(1, "timeout");
    end

endmodule
